layer_tile_loader: RTL and testbench

- Parametrised successor to the register file's fixed 8x8 weight/bias loading path.
- On a start command it fetches a rows x cols tile of packed DATA_WIDTH elements from word-addressed main memory and assembles it into a HEIGHT x WIDTH array. Unused elements are zero-padded.
- Presents the tile to the systolic-array feeder with a valid/ready handshake.
- Sits between the instruction decoder's load_weights/load_biases strobes and the systolic array.

---
 rtl/tpu_pkg.sv | 20 ++
 rtl/tile_word_unpacker.sv | 26 ++
 rtl/layer_tile_loader.sv | 190 +++++++++++++++++++
 tb/tb_layer_tile_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Types shared by the tile loading path: FSM states, the weight/bias tag
// and a ceiling-divide helper used to size each tile row in memory words.
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    typedef enum logic {
        KIND_WEIGHT = 1'b0,
        KIND_BIAS   = 1'b1
    } kind_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/tile_word_unpacker.sv
// Splits one memory word into its packed elements and flags which of them
// fall inside the valid column range of the tile row being fetched.
module tile_word_unpacker #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_WIDTH = 32,
    parameter int DIM_WIDTH  = 4,
    localparam int EPW       = WORD_WIDTH / DATA_WIDTH
) (
    input  logic [WORD_WIDTH-1:0]            word_i,
    input  logic [DIM_WIDTH-1:0]             word_idx_i,
    input  logic [DIM_WIDTH-1:0]             cols_i,
    output logic [EPW-1:0][DATA_WIDTH-1:0]   elem_o,
    output logic [EPW-1:0]                   we_o
);

    assign elem_o = word_i;

    // Element k of word w lands in column w*EPW+k; columns at or past cols stay zero.
    always_comb begin
        we_o = '0;
        for (int k = 0; k < EPW; k++) begin
            we_o[k] = (int'(word_idx_i) * EPW + k) < int'(cols_i);
        end
    end

endmodule

// File: rtl/layer_tile_loader.sv
// Fetches a rows x cols tile from word-addressed memory into a zero-padded
// HEIGHT x WIDTH buffer; define LAYER_TILE_TRANSPOSE_EN for transposed stores.
module layer_tile_loader
    import tpu_pkg::*;
#(
    parameter int HEIGHT     = 8,
    parameter int WIDTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DIM_WIDTH  = 4
) (
    input  logic                                         clk,
    input  logic                                         nrst,
    input  logic                                         start_iv,
    input  logic                                         kind_id,
    input  logic [ADDR_WIDTH-1:0]                        base_addr_id,
    input  logic [DIM_WIDTH-1:0]                         rows_id,
    input  logic [DIM_WIDTH-1:0]                         cols_id,
    input  logic                                         transpose_id,
    output logic [ADDR_WIDTH-1:0]                        mem_addr_od,
    output logic                                         mem_rd_o,
    input  logic [WORD_WIDTH-1:0]                        mem_data_id,
    output logic                                         busy_o,
    output logic                                         err_o,
    output logic                                         tile_ov,
    input  logic                                         tile_ready_i,
    output logic [HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0] tile_od,
    output logic                                         kind_od
);

    localparam int EPW = WORD_WIDTH / DATA_WIDTH;

    state_e                                       state_q, state_d;
    kind_e                                        kind_q, kind_d;
    logic [ADDR_WIDTH-1:0]                        fetch_addr_q, fetch_addr_d;
    logic [ADDR_WIDTH-1:0]                        last_addr_q, last_addr_d;
    logic [DIM_WIDTH-1:0]                         rows_q, rows_d, cols_q, cols_d;
    logic [DIM_WIDTH-1:0]                         wpr_q, wpr_d;
    logic [DIM_WIDTH-1:0]                         row_q, row_d, word_q, word_d;
    logic                                         transpose_q, transpose_d;
    logic                                         err_q, err_d;
    logic [HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0] tile_q, tile_d;

    logic [EPW-1:0][DATA_WIDTH-1:0]               elem;
    logic [EPW-1:0]                               elem_we;
    logic                                         tr_req;
    logic                                         start_bad;
    int                                           row_idx;
    int                                           col_base;

    tile_word_unpacker #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_WIDTH (WORD_WIDTH),
        .DIM_WIDTH  (DIM_WIDTH)
    ) u_unpacker (
        .word_i     (mem_data_id),
        .word_idx_i (word_q),
        .cols_i     (cols_q),
        .elem_o     (elem),
        .we_o       (elem_we)
    );

`ifdef LAYER_TILE_TRANSPOSE_EN
    assign tr_req = transpose_id;
`else
    logic unused_transpose;
    assign unused_transpose = transpose_id;
    assign tr_req           = 1'b0;
`endif

    // A transposed tile swaps which buffer dimension limits rows and cols.
    assign start_bad = (rows_id == '0) || (cols_id == '0) ||
                       (tr_req ? ((cols_id > DIM_WIDTH'(HEIGHT)) || (rows_id > DIM_WIDTH'(WIDTH)))
                               : ((rows_id > DIM_WIDTH'(HEIGHT)) || (cols_id > DIM_WIDTH'(WIDTH))));

    assign row_idx  = int'(row_q);
    assign col_base = int'(word_q) * EPW;

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        fetch_addr_d = fetch_addr_q;
        last_addr_d  = last_addr_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        wpr_d        = wpr_q;
        row_d        = row_q;
        word_d       = word_q;
        transpose_d  = transpose_q;
        err_d        = 1'b0;
        tile_d       = tile_q;

        case (state_q)
            IDLE: begin
                if (start_iv) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        kind_d       = kind_e'(kind_id);
                        rows_d       = rows_id;
                        cols_d       = cols_id;
                        wpr_d        = DIM_WIDTH'(ceil_div(int'(cols_id), EPW));
                        transpose_d  = tr_req;
                        fetch_addr_d = base_addr_id;
                        row_d        = '0;
                        word_d       = '0;
                        tile_d       = '0;
                        state_d      = FETCH;
                    end
                end
            end

            FETCH: begin
                // Reads are strictly sequential, so the address is just a wrapping increment.
                last_addr_d  = fetch_addr_q;
                fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(1);
                for (int i = 0; i < HEIGHT; i++) begin
                    for (int j = 0; j < WIDTH; j++) begin
                        for (int k = 0; k < EPW; k++) begin
                            if (elem_we[k]) begin
                                if (transpose_q ? ((j == row_idx) && (i == col_base + k))
                                                : ((i == row_idx) && (j == col_base + k))) begin
                                    tile_d[i][j] = elem[k];
                                end
                            end
                        end
                    end
                end
                if (word_q == wpr_q - DIM_WIDTH'(1)) begin
                    word_d = '0;
                    if (row_q == rows_q - DIM_WIDTH'(1)) begin
                        state_d = HOLD;
                    end else begin
                        row_d = row_q + DIM_WIDTH'(1);
                    end
                end else begin
                    word_d = word_q + DIM_WIDTH'(1);
                end
            end

            HOLD: begin
                if (tile_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= IDLE;
            kind_q       <= KIND_WEIGHT;
            fetch_addr_q <= '0;
            last_addr_q  <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            wpr_q        <= '0;
            row_q        <= '0;
            word_q       <= '0;
            transpose_q  <= 1'b0;
            err_q        <= 1'b0;
            tile_q       <= '0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            fetch_addr_q <= fetch_addr_d;
            last_addr_q  <= last_addr_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            wpr_q        <= wpr_d;
            row_q        <= row_d;
            word_q       <= word_d;
            transpose_q  <= transpose_d;
            err_q        <= err_d;
            tile_q       <= tile_d;
        end
    end

    assign mem_rd_o    = (state_q == FETCH);
    assign mem_addr_od = mem_rd_o ? fetch_addr_q : last_addr_q;
    assign busy_o      = (state_q != IDLE);
    assign tile_ov     = (state_q == HOLD);
    assign err_o       = err_q;
    assign tile_od     = tile_q;
    assign kind_od     = kind_q;

endmodule

// File: tb/tb_layer_tile_loader.sv
// Self-checking bench for layer_tile_loader: table vectors, handshake and reset
// sequences, and randomized loads checked against an element-level tile model.
module tb_layer_tile_loader;

    localparam int H   = 8;
    localparam int W   = 8;
    localparam int DW  = 8;
    localparam int WW  = 32;
    localparam int AW  = 8;
    localparam int DMW = 4;
    localparam int EPW = WW / DW;

    typedef struct {
        logic [AW-1:0] base;
        int            rows;
        int            cols;
        bit            tr;
        bit            kind;
        bit            exp_err;
        int            exp_reads;
    } vec_t;

    logic                          clk = 1'b0;
    logic                          nrst = 1'b0;
    logic                          start_iv = 1'b0;
    logic                          kind_id = 1'b0;
    logic [AW-1:0]                 base_addr_id = '0;
    logic [DMW-1:0]                rows_id = '0;
    logic [DMW-1:0]                cols_id = '0;
    logic                          transpose_id = 1'b0;
    logic                          tile_ready_i = 1'b0;
    logic [AW-1:0]                 mem_addr_od;
    logic                          mem_rd_o;
    logic [WW-1:0]                 mem_data_id;
    logic                          busy_o;
    logic                          err_o;
    logic                          tile_ov;
    logic                          kind_od;
    logic [H-1:0][W-1:0][DW-1:0]   tile_od;

    logic [WW-1:0]                 mem [256];
    logic [H-1:0][W-1:0][DW-1:0]   exp_tile;
    logic [AW-1:0]                 exp_addrs [$];
    bit                            exp_illegal;
    vec_t                          vecs [14];
    int                            total = 0;
    int                            bad = 0;

    layer_tile_loader dut (
        .clk          (clk),
        .nrst         (nrst),
        .start_iv     (start_iv),
        .kind_id      (kind_id),
        .base_addr_id (base_addr_id),
        .rows_id      (rows_id),
        .cols_id      (cols_id),
        .transpose_id (transpose_id),
        .mem_addr_od  (mem_addr_od),
        .mem_rd_o     (mem_rd_o),
        .mem_data_id  (mem_data_id),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .tile_ov      (tile_ov),
        .tile_ready_i (tile_ready_i),
        .tile_od      (tile_od),
        .kind_od      (kind_od)
    );

    always #5 clk = ~clk;

    assign mem_data_id = mem[mem_addr_od];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic compare_tile(input string name, input logic [H-1:0][W-1:0][DW-1:0] want);
        int nbad;
        nbad = 0;
        for (int i = 0; i < H; i++) begin
            for (int j = 0; j < W; j++) begin
                if (tile_od[i][j] !== want[i][j]) nbad++;
            end
        end
        checkOutput({name, "_elem_errors"}, 64'(nbad), 64'd0);
    endtask

    task automatic fill_pattern();
        for (int a = 0; a < 256; a++) begin
            mem[a] = {8'(a + 3), 8'(a + 2), 8'(a + 1), 8'(a)};
        end
    endtask

    // Reference: every source element (r,c) is located directly from its row's word span.
    task automatic build_model(input logic [AW-1:0] base, input int rows, input int cols, input bit tr);
        int            wpr;
        bit            tr_eff;
        logic [WW-1:0] word;
`ifdef LAYER_TILE_TRANSPOSE_EN
        tr_eff = tr;
`else
        tr_eff = tr & 1'b0;
`endif
        if (tr_eff) exp_illegal = (rows < 1) || (cols < 1) || (cols > H) || (rows > W);
        else        exp_illegal = (rows < 1) || (cols < 1) || (rows > H) || (cols > W);
        exp_tile = '0;
        exp_addrs.delete();
        if (!exp_illegal) begin
            wpr = (cols + EPW - 1) / EPW;
            for (int r = 0; r < rows; r++) begin
                for (int w = 0; w < wpr; w++) begin
                    exp_addrs.push_back(8'(int'(base) + r * wpr + w));
                end
            end
            for (int r = 0; r < rows; r++) begin
                for (int c = 0; c < cols; c++) begin
                    word = mem[8'(int'(base) + r * wpr + c / EPW)];
                    if (tr_eff) exp_tile[c][r] = word[(c % EPW) * DW +: DW];
                    else        exp_tile[r][c] = word[(c % EPW) * DW +: DW];
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [AW-1:0] base, input int rows, input int cols,
                                 input bit tr, input bit kind);
        base_addr_id = base;
        rows_id      = DMW'(rows);
        cols_id      = DMW'(cols);
        transpose_id = tr;
        kind_id      = kind;
        start_iv     = 1'b1;
        @(negedge clk);
        start_iv     = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit poke, input string tag);
        int reads;
        int addr_bad;
        int busy_bad;
        int cyc;
        build_model(v.base, v.rows, v.cols, v.tr);
        applyStimulus(v.base, v.rows, v.cols, v.tr, v.kind);
        if (v.exp_err) begin
            checkOutput({tag, "_err_pulse"}, err_o, 1);
            checkOutput({tag, "_err_busy"}, busy_o, 0);
            checkOutput({tag, "_err_rd"}, mem_rd_o, 0);
            @(negedge clk);
            checkOutput({tag, "_err_drop"}, err_o, 0);
            checkOutput({tag, "_err_busy2"}, busy_o, 0);
            checkOutput({tag, "_err_rd2"}, mem_rd_o, 0);
        end else begin
            reads = 0; addr_bad = 0; busy_bad = 0; cyc = 1;
            while (!tile_ov && cyc <= 40) begin
                if (mem_rd_o) begin
                    if (reads >= exp_addrs.size() || mem_addr_od !== exp_addrs[reads]) addr_bad++;
                    reads++;
                end
                if (!busy_o || err_o) busy_bad++;
                if (poke && cyc == 2) begin
                    start_iv     = 1'b1;
                    base_addr_id = 8'($urandom);
                    rows_id      = 4'd1;
                    cols_id      = 4'd1;
                    kind_id      = ~v.kind;
                end else begin
                    start_iv = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
            start_iv = 1'b0;
            checkOutput({tag, "_tile_ov"}, tile_ov, 1);
            checkOutput({tag, "_reads"}, 64'(reads), 64'(v.exp_reads));
            checkOutput({tag, "_ov_cycle"}, 64'(cyc), 64'(v.exp_reads + 1));
            checkOutput({tag, "_addr_errors"}, 64'(addr_bad), 64'd0);
            checkOutput({tag, "_busy_errors"}, 64'(busy_bad), 64'd0);
            checkOutput({tag, "_kind"}, kind_od, v.kind);
            compare_tile({tag, "_tile"}, exp_tile);
            tile_ready_i = 1'b1;
            @(negedge clk);
            tile_ready_i = 1'b0;
            checkOutput({tag, "_ov_drop"}, tile_ov, 0);
            checkOutput({tag, "_idle_busy"}, busy_o, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_tile_ov"}, tile_ov, 0);
        checkOutput({tag, "_busy"}, busy_o, 0);
        checkOutput({tag, "_err"}, err_o, 0);
        checkOutput({tag, "_rd"}, mem_rd_o, 0);
        checkOutput({tag, "_addr"}, mem_addr_od, 0);
        checkOutput({tag, "_kind"}, kind_od, 0);
        compare_tile({tag, "_tile"}, '0);
    endtask

    initial begin
        int   cyc;
        vec_t rv;

        vecs[0]  = '{8'h10, 8, 8, 1'b0, 1'b0, 1'b0, 16};
        vecs[1]  = '{8'h40, 3, 5, 1'b0, 1'b1, 1'b0, 6};
        vecs[2]  = '{8'hFE, 2, 3, 1'b0, 1'b0, 1'b0, 2};
        vecs[3]  = '{8'hFF, 3, 8, 1'b0, 1'b1, 1'b0, 6};
        vecs[4]  = '{8'h00, 9, 8, 1'b0, 1'b0, 1'b1, 0};
        vecs[5]  = '{8'h20, 4, 0, 1'b0, 1'b0, 1'b1, 0};
        vecs[6]  = '{8'h20, 0, 3, 1'b0, 1'b0, 1'b1, 0};
        vecs[7]  = '{8'h20, 1, 9, 1'b0, 1'b0, 1'b1, 0};
        vecs[8]  = '{8'h80, 1, 1, 1'b0, 1'b1, 1'b0, 1};
        vecs[9]  = '{8'h90, 8, 1, 1'b0, 1'b0, 1'b0, 8};
        vecs[10] = '{8'hA0, 2, 8, 1'b1, 1'b0, 1'b0, 4};
        vecs[11] = '{8'hA0, 9, 2, 1'b1, 1'b0, 1'b1, 0};
        vecs[12] = '{8'hB0, 5, 8, 1'b1, 1'b1, 1'b0, 10};
        vecs[13] = '{8'hC0, 7, 4, 1'b0, 1'b0, 1'b0, 7};

        fill_pattern();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        nrst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], 1'b1, $sformatf("vec%0d", i));
        end

        // Consumer stalls for five cycles; starts during the stall and at acceptance are dropped.
        build_model(8'h30, 2, 6, 1'b0);
        applyStimulus(8'h30, 2, 6, 1'b0, 1'b1);
        cyc = 1;
        while (!tile_ov && cyc <= 40) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("hs_ov_rise", tile_ov, 1);
        checkOutput("hs_ov_cycle", 64'(cyc), 64'd5);
        for (int n = 0; n < 5; n++) begin
            checkOutput($sformatf("hs_hold_ov%0d", n), tile_ov, 1);
            checkOutput($sformatf("hs_hold_rd%0d", n), mem_rd_o, 0);
            compare_tile($sformatf("hs_hold_tile%0d", n), exp_tile);
            if (n == 2) begin
                base_addr_id = 8'h00;
                rows_id      = 4'd1;
                cols_id      = 4'd1;
                kind_id      = 1'b0;
                start_iv     = 1'b1;
            end else begin
                start_iv = 1'b0;
            end
            @(negedge clk);
        end
        tile_ready_i = 1'b1;
        start_iv     = 1'b1;
        base_addr_id = 8'h50;
        rows_id      = 4'd2;
        cols_id      = 4'd2;
        kind_id      = 1'b0;
        @(negedge clk);
        tile_ready_i = 1'b0;
        start_iv     = 1'b0;
        checkOutput("hs_ov_drop", tile_ov, 0);
        checkOutput("hs_b2b_busy", busy_o, 0);
        checkOutput("hs_b2b_rd", mem_rd_o, 0);
        checkOutput("hs_kind_kept", kind_od, 1);
        compare_tile("hs_tile_kept", exp_tile);
        @(negedge clk);
        checkOutput("hs_b2b_busy2", busy_o, 0);

        // Reset on the fourth fetch cycle throws the partial tile away.
        applyStimulus(8'h20, 8, 8, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("rst_mid_rd", mem_rd_o, 1);
        nrst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        nrst = 1'b1;
        @(negedge clk);
        run_vec(vecs[1], 1'b0, "rst_reload");

        for (int it = 0; it < 24; it++) begin
            for (int a = 0; a < 256; a++) mem[a] = $urandom;
            rv.base = 8'($urandom);
            rv.rows = $urandom_range(0, 9);
            rv.cols = $urandom_range(0, 9);
            rv.tr   = 1'($urandom);
            rv.kind = 1'($urandom);
            build_model(rv.base, rv.rows, rv.cols, rv.tr);
            rv.exp_err   = exp_illegal;
            rv.exp_reads = exp_addrs.size();
            run_vec(rv, 1'b1, $sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
